encode_64b_66b_pcs: RTL

ENCODE_64B_66B_PCS -- requirements
Module: encode_64b_66b_pcs

---
 rtl/encode_64b_66b_pcs_pkg.sv | 105 ++++++++++
 rtl/encode_64b_66b_pcs_scrambler.sv | 54 +++++
 rtl/encode_64b_66b_pcs.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/encode_64b_66b_pcs_pkg.sv
// Shared definitions for the 64b/66b PCS transmit encoder: XGMII control
// characters, 66b block types, sync headers, transmit FSM states and the
// word classifier that turns one XGMII word into a 66b block.
package encode_64b_66b_pcs_pkg;

    // XGMII control characters
    localparam logic [7:0] XG_IDLE  = 8'h07;
    localparam logic [7:0] XG_START = 8'hFB;
    localparam logic [7:0] XG_TERM  = 8'hFD;
    localparam logic [7:0] XG_SEQ   = 8'h9C;
    localparam logic [7:0] XG_ERROR = 8'hFE;

    // 7-bit 66b control codes
    localparam logic [6:0] CC_IDLE  = 7'h00;
    localparam logic [6:0] CC_ERROR = 7'h1E;

    // 66b block type field values
    localparam logic [7:0]  BT_CTRL   = 8'h1E;
    localparam logic [7:0]  BT_START0 = 8'h78;
    localparam logic [7:0]  BT_START4 = 8'h33;
    localparam logic [7:0]  BT_ORDSET = 8'h4B;
    // Terminate block types, byte k holds the type for /T/ in lane k
    localparam logic [63:0] BT_TERM_TABLE = 64'hFFE1_D2CC_B4AA_9987;

    // Sync headers
    localparam logic [1:0] HDR_DATA = 2'b10;
    localparam logic [1:0] HDR_CTRL = 2'b01;

    // Transmit state machine encoding
    localparam logic [2:0] TX_INIT = 3'd0;
    localparam logic [2:0] TX_C    = 3'd1;
    localparam logic [2:0] TX_D    = 3'd2;
    localparam logic [2:0] TX_T    = 3'd3;
    localparam logic [2:0] TX_E    = 3'd4;

    // Error block payload: type 1E followed by eight /E/ control codes
    localparam logic [63:0] ERR_BLOCK = {{8{CC_ERROR}}, BT_CTRL};

    typedef enum logic [2:0] {
        BLK_C = 3'd0,
        BLK_S = 3'd1,
        BLK_D = 3'd2,
        BLK_T = 3'd3,
        BLK_E = 3'd4
    } blk_cls_e;

    typedef struct packed {
        blk_cls_e    cls;
        logic [1:0]  head;
        logic [63:0] data;
    } blk_t;

    // Classify one XGMII word and build its unscrambled 66b block.
    // Anything not matching a legal pattern becomes an error block.
    function automatic blk_t classify(input logic [63:0] txd, input logic [7:0] txc);
        blk_t b;
        logic hit;
        logic err_lane;
        b.cls    = BLK_E;
        b.head   = HDR_CTRL;
        b.data   = ERR_BLOCK;
        hit      = 1'b0;
        err_lane = 1'b0;
        for (int l = 0; l < 8; l++) begin
            err_lane = err_lane | (txc[l] & (txd[8*l +: 8] == XG_ERROR));
        end
        if (err_lane) begin
            b.cls = BLK_E;
        end else if (txc == 8'h00) begin
            b.cls  = BLK_D;
            b.head = HDR_DATA;
            b.data = txd;
        end else if ((txc == 8'h01) && (txd[7:0] == XG_START)) begin
            b.cls  = BLK_S;
            b.data = {txd[63:8], BT_START0};
        end else if ((txc == 8'h01) && (txd[7:0] == XG_SEQ)) begin
            b.cls  = BLK_C;
            b.data = {txd[63:40], 8'h00, txd[31:8], BT_ORDSET};
        end else if ((txc == 8'h1F) && (txd[39:32] == XG_START) &&
                     (txd[31:0] == {4{XG_IDLE}})) begin
            b.cls  = BLK_S;
            b.data = {txd[63:40], 32'h0000_0000, BT_START4};
        end else if ((txc == 8'hFF) && (txd == {8{XG_IDLE}})) begin
            b.cls  = BLK_C;
            b.data = {{8{CC_IDLE}}, BT_CTRL};
        end else begin
            for (int k = 0; k < 8; k++) begin
                hit = (txc == (8'hFF << k)) && (txd[8*k +: 8] == XG_TERM);
                for (int j = 0; j < 8; j++) begin
                    hit = hit && ((j <= k) || (txd[8*j +: 8] == XG_IDLE));
                end
                if (hit) begin
                    b.cls       = BLK_T;
                    b.data      = 64'h0;
                    b.data[7:0] = BT_TERM_TABLE[8*k +: 8];
                    for (int m = 1; m < 8; m++) begin
                        b.data[8*m +: 8] = (m <= k) ? txd[8*(m-1) +: 8] : 8'h00;
                    end
                end
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/encode_64b_66b_pcs_scrambler.sv
// 64-bit parallel x^58+x^39+1 self-synchronous scrambler with registered
// output. Bit 0 is the first bit on the line. In bypass the payload passes
// through unchanged and the polynomial state is left alone.
module scrambler_58
    import encode_64b_66b_pcs_pkg::*;
#(
    parameter logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        bypass_i,
    input  logic [63:0] data_i,
    output logic [63:0] data_o
);

    logic [57:0] state_r;
    logic [57:0] state_nxt_s;
    logic [63:0] scr_s;

    // Unrolled serial scrambler; returns {next_state, scrambled_word}
    function automatic logic [121:0] scramble64(input logic [57:0] s_in, input logic [63:0] d);
        logic [57:0] s;
        logic [63:0] o;
        s = s_in;
        o = 64'h0;
        for (int i = 0; i < 64; i++) begin
            o[i] = d[i] ^ s[38] ^ s[57];
            s    = {s[56:0], o[i]};
        end
        return {s, o};
    endfunction

    // Combinational scramble of the current word from the held state
    always_comb begin
        {state_nxt_s, scr_s} = scramble64(state_r, data_i);
    end

    // Output word and polynomial state advance only on valid input words
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= SEED;
            data_o  <= 64'h0;
        end else if (en_i) begin
            if (bypass_i) begin
                data_o <= data_i;
            end else begin
                data_o  <= scr_s;
                state_r <= state_nxt_s;
            end
        end
    end

endmodule

// File: rtl/encode_64b_66b_pcs.sv
// 64b/66b PCS transmit encoder. Stage 1 classifies the XGMII word, runs the
// transmit state machine and builds the 66b block; stage 2 scrambles the
// payload. Each stage only advances on a valid word, so a gearbox pause
// freezes data, header and scrambler state while valid keeps shifting.
module encode_64b_66b_pcs
    import encode_64b_66b_pcs_pkg::*;
#(
    parameter bit          SCRAMBLE_EN = 1'b1,
    parameter int          ERR_CNT_W   = 16,
    parameter logic [57:0] SCR_SEED    = 58'h3FF_FFFF_FFFF_FFFF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [63:0]          xgmii_txd_i,
    input  logic [7:0]           xgmii_txc_i,
    input  logic                 xgmii_txd_vld_i,
    input  logic                 err_clr_i,
    output logic [63:0]          encode_data_o,
    output logic [1:0]           encode_head_o,
    output logic                 encode_data_vld_o,
    output logic                 encode_error_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    blk_t                 blk_s;
    logic [2:0]           state_r;
    logic [2:0]           state_nxt_s;
    logic [63:0]          enc_data_s;
    logic [1:0]           enc_head_s;
    logic                 enc_err_s;
    logic [63:0]          enc_data_r;
    logic [1:0]           enc_head_r;
    logic                 enc_err_r;
    logic                 vld1_r;
    logic [1:0]           head2_r;
    logic                 vld2_r;
    logic                 err2_r;
    logic [ERR_CNT_W-1:0] err_cnt_r;
    logic                 bypass_s;

    assign bypass_s = ~SCRAMBLE_EN;

    // Classify the incoming XGMII word
    always_comb begin
        blk_s = classify(xgmii_txd_i, xgmii_txc_i);
    end

    // Transmit state machine next-state; unknown states fall to TX_E
    always_comb begin
        state_nxt_s = TX_E;
        case (state_r)
            TX_INIT, TX_C, TX_T: begin
                case (blk_s.cls)
                    BLK_C:   state_nxt_s = TX_C;
                    BLK_S:   state_nxt_s = TX_D;
                    default: state_nxt_s = TX_E;
                endcase
            end
            TX_D: begin
                case (blk_s.cls)
                    BLK_D:   state_nxt_s = TX_D;
                    BLK_T:   state_nxt_s = TX_T;
                    default: state_nxt_s = TX_E;
                endcase
            end
            TX_E: begin
                case (blk_s.cls)
                    BLK_C:   state_nxt_s = TX_C;
                    BLK_D:   state_nxt_s = TX_D;
                    BLK_T:   state_nxt_s = TX_T;
                    default: state_nxt_s = TX_E;
                endcase
            end
            default: state_nxt_s = TX_E;
        endcase
    end

    // Landing in TX_E replaces the word with an error block
    always_comb begin
        if (state_nxt_s == TX_E) begin
            enc_data_s = ERR_BLOCK;
            enc_head_s = HDR_CTRL;
            enc_err_s  = 1'b1;
        end else begin
            enc_data_s = blk_s.data;
            enc_head_s = blk_s.head;
            enc_err_s  = 1'b0;
        end
    end

    // Stage 1: register encoded block and FSM state on valid words
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld1_r     <= 1'b0;
            state_r    <= TX_INIT;
            enc_data_r <= 64'h0;
            enc_head_r <= 2'b00;
            enc_err_r  <= 1'b0;
        end else begin
            vld1_r <= xgmii_txd_vld_i;
            if (xgmii_txd_vld_i) begin
                state_r    <= state_nxt_s;
                enc_data_r <= enc_data_s;
                enc_head_r <= enc_head_s;
                enc_err_r  <= enc_err_s;
            end
        end
    end

    // Stage 2 payload: scrambler owns the registered output word
    scrambler_58 #(
        .SEED     (SCR_SEED)
    ) u_scrambler (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (vld1_r),
        .bypass_i (bypass_s),
        .data_i   (enc_data_r),
        .data_o   (encode_data_o)
    );

    // Stage 2 header, valid and error pulse alongside the scrambled payload
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld2_r  <= 1'b0;
            err2_r  <= 1'b0;
            head2_r <= 2'b00;
        end else begin
            vld2_r <= vld1_r;
            err2_r <= vld1_r & enc_err_r;
            if (vld1_r) begin
                head2_r <= enc_head_r;
            end
        end
    end

    // Saturating error-block counter; clear beats a coincident increment
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_r <= {ERR_CNT_W{1'b0}};
        end else if (err_clr_i) begin
            err_cnt_r <= {ERR_CNT_W{1'b0}};
        end else if (vld1_r && enc_err_r && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign encode_head_o     = head2_r;
    assign encode_data_vld_o = vld2_r;
    assign encode_error_o    = err2_r;
    assign err_cnt_o         = err_cnt_r;

endmodule
